// File: rtl/seq_alu_rnd.sv
// Multi-cycle ALU: add, sub, logical shift, and iterative shift-add multiply
// with optional rounded/saturated fixed-point output, behind valid/ready handshakes.
module seq_alu_rnd #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic             rnd_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   W_LIM = WIDTH'(WIDTH);
  localparam logic [2*WIDTH:0]   HALF  = (2*WIDTH+1)'(1) << (FRAC_BITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_r, mplier;
  logic [WIDTH:0]     acc;
  logic [CW-1:0]      cnt;
  logic               rnd_r;

  logic               accept, last_step, sat;
  logic [WIDTH:0]     add_sum, sub_dif, addend, step_sum;
  logic [WIDTH-1:0]   shift_res;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0]   rsum;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(WIDTH - 1));

  assign add_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sub_dif   = {1'b0, a} - {1'b0, b};
  assign shift_res = (b >= W_LIM) ? '0 : (mode ? (a >> b) : (a << b));

  // The last shift-add step and the rounding share one edge: the final product
  // is the post-step accumulator concatenated with the not-yet-shifted multiplier bits.
  assign addend   = mplier[0] ? {1'b0, a_r} : '0;
  assign step_sum = acc + addend;
  assign prod     = {step_sum, mplier[WIDTH-1:1]};
  assign rsum     = {1'b0, prod} + HALF;
  assign sat      = (rsum >> (FRAC_BITS + WIDTH)) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (op == 2'b10) ? CALC : DONE;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      a_r       <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      rnd_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          result_hi <= '0;
          carry     <= 1'b0;
          overflow  <= 1'b0;
          case (op)
            2'b00: begin
              result   <= add_sum[WIDTH-1:0];
              carry    <= add_sum[WIDTH];
              overflow <= (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
              result   <= sub_dif[WIDTH-1:0];
              carry    <= sub_dif[WIDTH];
              overflow <= (a[WIDTH-1] != b[WIDTH-1]) && (sub_dif[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10: begin
              a_r    <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              rnd_r  <= rnd_en;
            end
            default: result <= shift_res;
          endcase
        end
        CALC: begin
          acc    <= {1'b0, step_sum[WIDTH:1]};
          mplier <= {step_sum[0], mplier[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            carry <= 1'b0;
            if (rnd_r) begin
              result_hi <= '0;
              result    <= sat ? '1 : rsum[FRAC_BITS +: WIDTH];
              overflow  <= sat;
            end else begin
              result_hi <= prod[2*WIDTH-1:WIDTH];
              result    <= prod[WIDTH-1:0];
              overflow  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_alu_rnd.md
Name: seq_alu_rnd

Overview:
Parametrised, multi-cycle successor to the 16-bit combinational ALU. It performs add, subtract, iterative shift-add multiply with optional fixed-point round-off and saturation, and logical shift. Operands enter and results leave through a valid/ready handshake. The block sits between the operand register file and the writeback stage, and it handles one operation in flight at a time.

Parameters:
WIDTH, 16, operand and result width in bits (>=4)
FRAC_BITS, 8, fractional bits used by the rounded multiply (1..WIDTH-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand bundle valid
in_ready  out  1  block can accept a bundle
op  in  2  00 add, 01 sub, 10 mul, 11 shift
mode  in  1  shift: 0 left / 1 right logical; ignored otherwise
rnd_en  in  1  mul only: 1 = rounded and saturated Q-format result
a  in  WIDTH  operand A (unsigned; signed view used for overflow)
b  in  WIDTH  operand B / shift amount
cin  in  1  carry in (add only)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
result  out  WIDTH  result (mul with rnd_en=0: low half of product)
result_hi  out  WIDTH  mul with rnd_en=0: high half of product; 0 for all other cases
carry  out  1  add: carry out; sub: borrow (a<b unsigned); otherwise 0
overflow  out  1  add/sub: signed overflow; rounded mul: saturation occurred; otherwise 0
busy  out  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset: state IDLE; result, result_hi, carry, overflow, out_valid and busy are all 0. in_ready = (state==IDLE) && rst_n.
- FSM states:
  - IDLE: a bundle is accepted on a clk edge where in_valid && in_ready, and a/b/op/mode/rnd_en/cin are captured. Add, sub and shift are computed on that edge and go straight to DONE. Mul goes to CALC with the counter at 0.
  - CALC: performs one shift-add step per cycle (LSB-first on the multiplier, accumulator of WIDTH+1 bits). Leaves for DONE after exactly WIDTH steps. On the transition, a final edge applies rounding and formatting.
  - DONE: out_valid=1 and all outputs are held stable. On out_ready the state returns to IDLE and out_valid drops on that edge. in_valid is ignored while not IDLE.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - add, sub, shift: 1 cycle.
  - mul: WIDTH+1 cycles.
  - Throughput is one operation per latency+1 cycles with no back-pressure; there is no accept in the same cycle as the output handshake.
- add: result = (a+b+cin) mod 2^WIDTH. carry is the carry out of the MSB. overflow is set when a and b have the same sign and result has a different sign.
- sub: result = (a-b) mod 2^WIDTH. carry = 1 iff a<b unsigned. Signed overflow is computed the usual way. cin is ignored.
- shift:
  - If b >= WIDTH (the full b value is compared), result = 0.
  - Otherwise result = a<<b when mode=0, or a>>b when mode=1, with zero fill.
- mul, unsigned, P = a*b (2*WIDTH bits):
  - rnd_en=0: {result_hi,result} = P and overflow = 0.
  - rnd_en=1: R = (P + 2^(FRAC_BITS-1)) >> FRAC_BITS, which rounds half up. If R >= 2^WIDTH, result = all ones and overflow = 1; otherwise result = R. result_hi = 0.
- Reset mid-operation: an assertion in any state returns immediately to reset values, and the partial product is discarded. The first accept is possible on the first edge after deassertion.
- Simultaneous events: in DONE with out_ready=1 and in_valid=1, only the output handshake completes; the new bundle is accepted on a later edge.

Test Plan:
- add, a=0xFFFF, b=0x0001, cin=0 -> after 1 cycle: result=0x0000, carry=1, overflow=0; a=0x7FFF, b=0x0001 -> result=0x8000, overflow=1.
- sub, a=0x0003, b=0x0005 -> result=0xFFFE, carry=1; a=0x8000, b=0x0001 -> result=0x7FFF, overflow=1.
- mul, rnd_en=0, a=0x1234, b=0x5678 -> out_valid exactly 17 cycles after accept; result_hi=0x0626, result=0x0060. in_ready=0 throughout CALC.
- mul, rnd_en=1: a=0x0180, b=0x0280 -> result=0x03C0; a=0x0001, b=0x0080 -> result=0x0001 (rounds up); a=0xFFFF, b=0xFFFF -> result=0xFFFF, overflow=1.
- shift: a=0x8001, b=4, mode=0 -> result=0x0010; mode=1 -> result=0x0800; b=16 -> result=0x0000.
- Back-pressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs are stable and a new in_valid is ignored.
  - Pull rst_n low at CALC step 7 -> out_valid=0 and busy=0 immediately; the next mul completes correctly.
